// File: rtl/lookup_table_rom_if.sv
// Index/entry bundle for the CORDIC arctangent ROM: index in, Q15.16 angle and out-of-range flag out.
// Stateless interface; no backpressure (values are pure data, no handshake).
interface lookup_table_rom_if;
    logic        [31:0] i;
    logic signed [31:0] rom;
    logic               oor;

    modport master (output i, input rom, input oor);
    modport slave  (input i, output rom, output oor);
endinterface

// File: rtl/lookup_table_rom.sv
// CORDIC arctangent ROM: atan(2^-i) in degrees, Q15.16; oor flags i >= DEPTH (full 32-bit compare).
// Latency 0 by default; 1 cycle when LUT_OUT_REG_EN is defined (sync active-low reset clears outputs).
// No backpressure: output follows the index every cycle; macro LUT_OUT_REG_EN selects registered outputs.
module lookup_table_rom #(
    parameter int DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    lookup_table_rom_if.slave   bus
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    // round(atan(2^-idx) * 180/pi * 65536), half-up; entries past 22 round to zero
    function automatic logic [31:0] atan_entry(input logic [4:0] idx);
        logic [31:0] val;
        case (idx)
            5'd0:    val = 32'd2949120;
            5'd1:    val = 32'd1740967;
            5'd2:    val = 32'd919879;
            5'd3:    val = 32'd466945;
            5'd4:    val = 32'd234379;
            5'd5:    val = 32'd117304;
            5'd6:    val = 32'd58666;
            5'd7:    val = 32'd29335;
            5'd8:    val = 32'd14668;
            5'd9:    val = 32'd7334;
            5'd10:   val = 32'd3667;
            5'd11:   val = 32'd1833;
            5'd12:   val = 32'd917;
            5'd13:   val = 32'd458;
            5'd14:   val = 32'd229;
            5'd15:   val = 32'd115;
            5'd16:   val = 32'd57;
            5'd17:   val = 32'd29;
            5'd18:   val = 32'd14;
            5'd19:   val = 32'd7;
            5'd20:   val = 32'd4;
            5'd21:   val = 32'd2;
            5'd22:   val = 32'd1;
            default: val = 32'd0;
        endcase
        return val;
    endfunction

    logic        in_range;
    logic [31:0] rom_d;
    logic        oor_d;

    always_comb begin
        in_range = (bus.i < DEPTH_W);
        oor_d    = ~in_range;
        rom_d    = in_range ? atan_entry(bus.i[4:0]) : 32'd0;
    end

`ifdef LUT_OUT_REG_EN
    logic [31:0] rom_q;
    logic        oor_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_q <= 32'd0;
            oor_q <= 1'b0;
        end else begin
            rom_q <= rom_d;
            oor_q <= oor_d;
        end
    end

    assign bus.rom = $signed(rom_q);
    assign bus.oor = oor_q;
`else
    // The CORDIC datapath consumes the entry in the same cycle it presents i.
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;

    assign bus.rom = $signed(rom_d);
    assign bus.oor = oor_d;
`endif

endmodule

// File: tb/tb_lookup_table_rom.sv
// Scoreboard bench for lookup_table_rom: stimulus pushes expected results, a negedge monitor pops and compares.
// Covers the table sweep, out-of-range indices and, when LUT_OUT_REG_EN is defined, reset and register timing.
module tb_lookup_table_rom;

`ifdef LUT_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    lookup_table_rom_if bus ();

    lookup_table_rom #(.DEPTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Hand-computed round(atan(2^-k)*180/pi*65536) for k = 0..31
    logic [31:0] golden [32];
    initial begin
        golden = '{32'd2949120, 32'd1740967, 32'd919879, 32'd466945, 32'd234379, 32'd117304,
                   32'd58666, 32'd29335, 32'd14668, 32'd7334, 32'd3667, 32'd1833, 32'd917,
                   32'd458, 32'd229, 32'd115, 32'd57, 32'd29, 32'd14, 32'd7, 32'd4, 32'd2,
                   32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    end

    typedef struct {
        logic [31:0] idx;
        logic [31:0] rom;
        logic        oor;
        int          due;
    } exp_t;

    exp_t sb [$];

    task automatic drive(input logic [31:0] idx, input logic rst_val);
        exp_t e;
        @(posedge clk);
        #1;
        bus.i = idx;
        rst_n = rst_val;
        e.idx = idx;
        e.due = cyc + LAT;
`ifdef LUT_OUT_REG_EN
        if (!rst_val) begin
            e.rom = 32'd0;
            e.oor = 1'b0;
        end else
`endif
        if (idx >= 32'd32) begin
            e.rom = 32'd0;
            e.oor = 1'b1;
        end else begin
            e.rom = golden[idx[4:0]];
            e.oor = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation whose due cycle has arrived
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.due != cyc) begin
                    n_errors++;
                    $display("FAIL late_check i=%0d: checked at cycle %0d, required cycle %0d", e.idx, cyc, e.due);
                end else if (bus.rom !== $signed(e.rom) || bus.oor !== e.oor) begin
                    n_errors++;
                    $display("FAIL lookup i=0x%08h cyc=%0d: rom=%0d oor=%b, expected rom=%0d oor=%b",
                             e.idx, cyc, bus.rom, bus.oor, e.rom, e.oor);
                end
                n_checks++;
                if (bus.rom[31] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL sign i=0x%08h: rom[31]=%b, expected 0", e.idx, bus.rom[31]);
                end
            end
        end
    end

    initial begin
        bus.i = 32'd0;
`ifdef LUT_OUT_REG_EN
        // Reset held two edges with i=0, then release
        drive(32'd0, 1'b0);
        drive(32'd0, 1'b0);
        drive(32'd0, 1'b1);
        // i changes 1 -> 3 between edges
        drive(32'd1, 1'b1);
        drive(32'd3, 1'b1);
        // Reset mid-stream wins over lookup of i=2
        drive(32'd2, 1'b1);
        drive(32'd2, 1'b0);
        drive(32'd2, 1'b1);
        drive(32'd40, 1'b1);
        drive(32'd5, 1'b1);
`else
        // Combinational mode ignores rst_n entirely
        drive(32'd0, 1'b0);
        drive(32'd22, 1'b0);
        drive(32'd40, 1'b0);
`endif
        for (int k = 0; k < 32; k++) drive(k[31:0], 1'b1);
        drive(32'd22, 1'b1);
        drive(32'd23, 1'b1);
        drive(32'd32, 1'b1);
        drive(32'd33, 1'b1);
        drive(32'h0000_0100, 1'b1);
        drive(32'h0001_0000, 1'b1);
        drive(32'h8000_0000, 1'b1);
        drive(32'hFFFF_FFFF, 1'b1);
        drive(32'd4, 1'b1);
        drive(32'hFFFF_FFE0, 1'b1);
        drive(32'd31, 1'b1);

        repeat (4) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lookup_table_rom.md
LOOKUP_TABLE_ROM -- requirements
Module: lookup_table

Interface
REQ-001 Parameter: DEPTH, default 32, number of valid table entries (legal 1..32); indices >= DEPTH are out of range.
REQ-002 Port: clk  input  1  rising-edge clock; used only when LUT_OUT_REG_EN is defined.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low; used only when LUT_OUT_REG_EN is defined.
REQ-004 Port: i  input  32  unsigned CORDIC iteration index.
REQ-005 Port: rom  output  32  signed arctangent entry atan(2^-i), degrees, Q15.16 two's complement.
REQ-006 Port: oor  output  1  high when i >= DEPTH.

Function
REQ-007 Entry value SHALL be round(atan(2^-i) * 180/pi * 65536), with round-half-up, for 0 <= i < DEPTH.
REQ-008 The table SHALL hold the following low-index values:
- i=0: 2949120 (0x002D0000)
- i=1: 1740967
- i=2: 919879
- i=3: 466945
- i=4: 234379
- i=5: 117304
REQ-009 Entries SHALL decrease monotonically; i=22 SHALL give 1, and i=23..DEPTH-1 SHALL give 0.
REQ-010 For i >= DEPTH, including i = 0xFFFFFFFF, rom SHALL be 0 and oor SHALL be 1; all 32 bits of i are compared, with no truncation or wrap-around.
REQ-011 For i < DEPTH, oor SHALL be 0.
REQ-012 All entries SHALL be non-negative; bit 31 of rom SHALL never be 1.
REQ-013 The table SHALL be a constant ROM; it has no write path and no internal state other than the optional output register.

Reset
REQ-014 With LUT_OUT_REG_EN defined: when rst_n=0 at a rising clk edge, rom SHALL become 0 and oor SHALL become 0 on that edge.
REQ-015 Reset SHALL take priority over the lookup in the same cycle.
REQ-016 After rst_n returns high, the first rising edge SHALL load the entry for the current i.
REQ-017 Without LUT_OUT_REG_EN, rst_n SHALL have no effect and the outputs SHALL have no reset value; they always reflect i.

Configuration
REQ-018 Macro LUT_OUT_REG_EN SHALL select the output timing.
REQ-019 With LUT_OUT_REG_EN defined: rom and oor SHALL be registered.
- Latency is 1 cycle: values for i sampled at edge k appear after edge k and hold until the next edge.
REQ-020 With LUT_OUT_REG_EN undefined (default): rom and oor SHALL be purely combinational functions of i.
- Latency is 0 cycles; clk and rst_n are ignored.
- This mode is the one used by the CORDIC iteration datapath, which applies rom in the same cycle it presents i.
REQ-021 Table contents and out-of-range rules SHALL be identical in both modes.

Verification
REQ-022 Combinational mode, sweep i=0..5 -> rom = 2949120, 1740967, 919879, 466945, 234379, 117304; oor=0.
REQ-023 Combinational mode, i=22 -> rom=1, oor=0; i=23 -> rom=0, oor=0; i=32 -> rom=0, oor=1; i=0xFFFFFFFF -> rom=0, oor=1.
REQ-024 Registered mode, rst_n=0 for 2 edges with i=0 -> rom=0, oor=0; release rst_n -> after the next edge rom=2949120.
REQ-025 Registered mode, change i from 1 to 3 between edges -> rom stays 1740967 until the next edge, then becomes 466945.
REQ-026 Registered mode, rst_n=0 asserted while i=2 mid-stream -> rom=0 on that edge; i=40 with rst_n=1 -> next edge rom=0, oor=1.
REQ-027 Full sweep i=0..31 against a double-precision model using the REQ-007 formula -> exact match on every entry in both modes; rom is never negative.
